// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light timing path.
// Provides the timer FSM states and the reset interval constants.
package traffic_pkg;

  typedef enum logic {
    IDLE,
    COUNT
  } timer_state_e;

  localparam int DEF_NUM_PARAMS = 4;
  localparam int DEF_VAL_W      = 4;
  localparam int DEF_TICK_DIV   = 1;

  localparam logic [DEF_VAL_W-1:0] DEF_RED    = 4'd9;
  localparam logic [DEF_VAL_W-1:0] DEF_GREEN  = 4'd6;
  localparam logic [DEF_VAL_W-1:0] DEF_YELLOW = 4'd3;
  localparam logic [DEF_VAL_W-1:0] DEF_ALL    = 4'd2;

  localparam logic [DEF_NUM_PARAMS*DEF_VAL_W-1:0]
    DEF_INTERVALS = {DEF_RED, DEF_GREEN, DEF_YELLOW, DEF_ALL};

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle ticks every TICK_DIV enabled cycles.
// Ports: clk, rst_n (async low), clear, enable -> tick.
module tick_prescaler #(
  parameter int TICK_DIV = 1,
  parameter int W        = $clog2(TICK_DIV + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/interval_timer_bank.sv
// Shadow-buffered interval bank plus prescaled countdown for the traffic FSM.
// Ports: programming (selector/value/strobe), FSM start/select, timer status.
module interval_timer_bank
  import traffic_pkg::*;
#(
  parameter int NUM_PARAMS = DEF_NUM_PARAMS,
  parameter int VAL_W      = DEF_VAL_W,
  parameter int SEL_W      = $clog2(NUM_PARAMS),
  parameter logic [NUM_PARAMS*VAL_W-1:0]
                DEFAULT_VALUES = DEF_INTERVALS,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic             clk,
  input  logic             global_reset_n,
  input  logic [SEL_W-1:0] time_param_selector,
  input  logic [VAL_W-1:0] input_time_value,
  input  logic             reprogram,
  input  logic [SEL_W-1:0] fsm_requested_interval,
  input  logic             start_timer,
  output logic [VAL_W-1:0] output_time_value,
  output logic [VAL_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             reprogram_pending,
  output logic             program_error
);

  timer_state_e state_q, state_d;

  logic [VAL_W-1:0] active_q [NUM_PARAMS];
  logic [VAL_W-1:0] shadow_q [NUM_PARAMS];
  logic [NUM_PARAMS-1:0] pend_q;

  logic [VAL_W-1:0] rem_d;
  logic [VAL_W-1:0] act_val;
  logic [VAL_W-1:0] eff_val;
  logic busy_d;
  logic exp_d;
  logic load;
  logic tick;
  logic wr_ok;
  logic req_ok;

  assign wr_ok = reprogram
              && (input_time_value != '0)
              && (int'(time_param_selector) < NUM_PARAMS);
  assign req_ok = int'(fsm_requested_interval) < NUM_PARAMS;
  assign reprogram_pending = |pend_q;

  // A pending shadow value is what IDLE commits on this edge,
  // so a start here must see it rather than the stale active copy.
  always_comb begin
    act_val = '0;
    eff_val = '0;
    if (req_ok) begin
      act_val = active_q[fsm_requested_interval];
      eff_val = pend_q[fsm_requested_interval]
              ? shadow_q[fsm_requested_interval]
              : active_q[fsm_requested_interval];
    end
  end

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (global_reset_n),
    .clear (load),
    .enable(state_q == COUNT),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    busy_d  = busy;
    exp_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_timer && req_ok) begin
          load    = 1'b1;
          rem_d   = eff_val;
          busy_d  = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Restart takes priority over a coincident final tick.
        if (start_timer && req_ok) begin
          load  = 1'b1;
          rem_d = act_val;
        end else if (tick) begin
          if (remaining == VAL_W'(1)) begin
            rem_d   = '0;
            busy_d  = 1'b0;
            exp_d   = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d = remaining - VAL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q   <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state_q   <= state_d;
      remaining <= rem_d;
      busy      <= busy_d;
      expired   <= exp_d;
    end
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        active_q[i] <= DEFAULT_VALUES[i*VAL_W +: VAL_W];
        shadow_q[i] <= DEFAULT_VALUES[i*VAL_W +: VAL_W];
      end
      pend_q            <= '0;
      program_error     <= 1'b0;
      output_time_value <= DEFAULT_VALUES[VAL_W-1:0];
    end else begin
      program_error <= reprogram && !wr_ok;
      if (req_ok) begin
        output_time_value <= act_val;
      end
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if ((state_q == IDLE) && pend_q[i]) begin
          active_q[i] <= shadow_q[i];
          pend_q[i]   <= 1'b0;
        end
        // A new write re-arms pend even if this edge committed.
        if (wr_ok && (int'(time_param_selector) == i)) begin
          shadow_q[i] <= input_time_value;
          pend_q[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_interval_timer_bank.sv
// Scoreboard bench for interval_timer_bank (3 params, TICK_DIV=3).
// Expected pulses are queued by stimulus and matched by a monitor.
module tb_interval_timer_bank;

  localparam int NP = 3;
  localparam int VW = 4;
  localparam int SW = 2;
  localparam int TD = 3;

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] sel;
  logic [VW-1:0] val;
  logic          reprogram;
  logic [SW-1:0] req;
  logic          start;
  logic [VW-1:0] otv;
  logic [VW-1:0] remaining;
  logic          busy;
  logic          expired;
  logic          pending;
  logic          perr;

  interval_timer_bank #(
    .NUM_PARAMS    (NP),
    .VAL_W         (VW),
    .SEL_W         (SW),
    .DEFAULT_VALUES({4'd6, 4'd3, 4'd2}),
    .TICK_DIV      (TD)
  ) dut (
    .clk                   (clk),
    .global_reset_n        (rst_n),
    .time_param_selector   (sel),
    .input_time_value      (val),
    .reprogram             (reprogram),
    .fsm_requested_interval(req),
    .start_timer           (start),
    .output_time_value     (otv),
    .remaining             (remaining),
    .busy                  (busy),
    .expired               (expired),
    .reprogram_pending     (pending),
    .program_error         (perr)
  );

  typedef struct {
    bit is_exp;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req_v);
    n_total++;
    if (act == req_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, req_v, cyc);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit is_exp, input int at);
    ev_t e;
    e.is_exp = is_exp;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_exp(input string name, input int budget);
    int n = 0;
    while (!expired && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(expired), 1);
  endtask

  // Monitor: every expired / program_error pulse must match the queue head.
  always @(posedge clk) begin
    ev_t e;
    #2;
    if (rst_n && (expired || perr)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(expired) * 2 + int'(perr), 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", int'(expired), int'(e.is_exp));
        chk("pulse_cycle", cyc, e.at);
        if (expired) begin
          chk("exp_remaining", int'(remaining), 0);
          chk("exp_busy", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sel = '0; val = '0; reprogram = 1'b0;
    req = '0; start = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // 1: reset in the middle of a count
    req = 2; start = 1'b1;
    push(1'b1, cyc + 1 + 6 * TD);
    step();
    start = 1'b0;
    chk("t1_load", int'(remaining), 6);
    step(4);
    chk("t1_busy", int'(busy), 1);
    chk("t1_rem", int'(remaining), 5);
    rst_n = 1'b0;
    exp_q.delete();
    req = 0;
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_exp", int'(expired), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_perr", int'(perr), 0);
    chk("rst_otv", int'(otv), 2);
    step();
    rst_n = 1'b1;
    step(25);
    chk("t1_idle", int'(busy), 0);

    // 2: idle reprogram of sel 1 to 9
    req = 1;
    sel = 1; val = 9; reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    chk("t2_pend", int'(pending), 1);
    step();
    chk("t2_pend_clr", int'(pending), 0);
    chk("t2_otv_old", int'(otv), 3);
    step();
    chk("t2_otv_new", int'(otv), 9);

    // 3: count 9 ticks of 3 cycles
    start = 1'b1;
    push(1'b1, cyc + 1 + 9 * TD);
    step();
    start = 1'b0;
    for (int i = 0; i < 9 * TD; i++) begin
      chk("t3_busy", int'(busy), 1);
      chk("t3_rem", int'(remaining), 9 - i / TD);
      step();
    end
    chk("t3_done", int'(busy), 0);
    chk("t3_pulse", int'(expired), 1);
    step();
    chk("t3_single", int'(expired), 0);

    // 4: write during count is deferred until after expiry
    start = 1'b1;
    push(1'b1, cyc + 1 + 9 * TD);
    step();
    start = 1'b0;
    step(2);
    sel = 1; val = 12; reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    chk("t4_pend", int'(pending), 1);
    chk("t4_rem", int'(remaining), 8);
    wait_exp("t4_expire", 40);
    chk("t4_pend_held", int'(pending), 1);
    chk("t4_otv_held", int'(otv), 9);
    step();
    chk("t4_commit", int'(pending), 0);
    step();
    chk("t4_otv_new", int'(otv), 12);

    // 5: rejected writes
    sel = 0; val = 0; reprogram = 1'b1;
    push(1'b0, cyc + 1);
    step();
    reprogram = 1'b0;
    chk("t5_err0", int'(perr), 1);
    step();
    chk("t5_err0_clr", int'(perr), 0);
    sel = 3; val = 5; reprogram = 1'b1;
    push(1'b0, cyc + 1);
    step();
    reprogram = 1'b0;
    step();
    chk("t5_no_pend", int'(pending), 0);
    chk("t5_otv1", int'(otv), 12);
    req = 0;
    step();
    chk("t5_otv0", int'(otv), 2);
    req = 2;
    step();
    chk("t5_otv2", int'(otv), 6);
    req = 3; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_bad_start", int'(busy), 0);

    // 6a: restart mid-count reloads, old expiry cancelled
    req = 2; start = 1'b1;
    push(1'b1, cyc + 1 + 6 * TD);
    step();
    start = 1'b0;
    step(4);
    chk("t6_rem", int'(remaining), 5);
    req = 0; start = 1'b1;
    void'(exp_q.pop_back());
    push(1'b1, cyc + 1 + 2 * TD);
    step();
    start = 1'b0;
    chk("t6_reload", int'(remaining), 2);
    chk("t6_busy", int'(busy), 1);
    wait_exp("t6_expire", 20);

    // 6b: start while a write is pending forwards it
    sel = 2; val = 4; reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    chk("t6_pend", int'(pending), 1);
    req = 2; start = 1'b1;
    push(1'b1, cyc + 1 + 4 * TD);
    step();
    start = 1'b0;
    chk("t6_fwd", int'(remaining), 4);
    chk("t6_fwd_pend", int'(pending), 0);
    wait_exp("t6_fwd_exp", 20);
    chk("t6_otv", int'(otv), 4);

    step(3);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
